mem_responder: RTL
==================

# mem_responder

Memory-side responder for the processor's multiplexed 16-bit address/data bus. It latches the address when ALE is high, then services one read (nOE low) or one write (nWE low) while chip-select nME is low. Reads come from an internal word-addressed memory array and are driven on a separate output bus with an output enable. It sits opposite the control unit's fetch and load/store sequencing and serves as both the system-level memory model and the synthesizable on-chip RAM front end. A back-door load port lets a bench or boot loader preload program and data.

## Interface

Parameters:
- `AW`, 8: address width in words; depth is 2**AW.
- `DW`, 16: data and bus width.

Ports:
- `Clock` in 1: single system clock, rising-edge active.
- `nReset` in 1: asynchronous, active-low reset.
- `BusIn` in DW: bus value seen from the processor, carrying the address during ALE and write data during nWE.
- `ALE` in 1: address latch enable, active high.
- `nME` in 1: memory chip select, active low.
- `nOE` in 1: output (read) strobe, active low.
- `nWE` in 1: write strobe, active low.
- `DataOut` out DW: read data.
- `DataOe` out 1: high while the responder drives `DataOut` onto the bus.
- `ProtErr` out 1: sticky protocol error flag.
- `LoadWe` in 1: back-door write enable.
- `LoadAddr` in AW: back-door address.
- `LoadData` in DW: back-door data.

## Operation

- FSM states: `IDLE`, `ADDR`, `READ`, `WRITE`.
- Address latch rule:
  - An edge that samples `ALE`=1 loads `AddrReg <= BusIn[AW-1:0]`, moves to `ADDR` and clears `DataOe`.
  - This happens from any state, which means ALE aborts an access in progress.
  - Upper bus bits are ignored, so addresses wrap modulo 2**AW.
- `ADDR`, read: an edge that samples `nME`=0, `nOE`=0, `nWE`=1 does the following:
  - registers `DataOut <= mem[AddrReg]`;
  - sets `DataOe`=1;
  - moves to `READ`.
- `READ`:
  - `DataOut` and `DataOe` hold while `nOE`=0 and `nME`=0.
  - An edge that samples either signal high clears `DataOe` and moves to `IDLE`. `DataOut` keeps its last value.
- `ADDR`, write: an edge that samples `nME`=0, `nWE`=0, `nOE`=1 does the following:
  - writes `mem[AddrReg] <= BusIn`;
  - moves to `WRITE`.
- `WRITE`:
  - Exactly one array write happens per strobe; further edges with `nWE`=0 do not write.
  - An edge that samples `nWE`=1 moves to `IDLE`.
- Chip select: with `nME`=1, strobes are ignored, no write occurs and `DataOe` stays 0.
- Strobe conflict: if `nOE`=0 and `nWE`=0 are sampled together while `nME`=0 in `ADDR`, `READ` or `WRITE`:
  - `ProtErr` is set;
  - no write occurs;
  - `DataOe` is cleared;
  - the FSM moves to `IDLE`.
  - `ProtErr` clears only on reset.
- Strobes in `IDLE` (no ALE since the last access) are ignored; no write, no read.
- Back-door load:
  - `LoadWe`=1 writes `mem[LoadAddr] <= LoadData` on the edge, in any state.
  - If a bus write and a load hit the same address on the same edge, the bus write wins.
  - Loads to other addresses proceed in parallel.
- Reset:
  - `DataOut`=0, `DataOe`=0, `ProtErr`=0, `AddrReg`=0, state `IDLE`.
  - Memory contents are not reset.
  - Reset asserted mid-access drops `DataOe` immediately, asynchronously.

## Timing

- Processor fetch sequence, one signal set per cycle:
  - C0: `MemEn`.
  - C1: `ALE`=1, `nOE`=`nWE`=1.
  - C2: idle.
  - C3: `nOE`=0.
  - C4: processor captures the instruction (`IrWe`).
- Address latch: the address is latched at the end of C1.
- Read latency: 1 cycle from the edge that samples `nOE`=0 (end of C3) to `DataOut` valid with `DataOe`=1. Data is valid throughout C4, so the processor's end-of-C4 capture succeeds.
- Read data source: the array read in `ADDR` uses the `AddrReg` value latched on an earlier edge. There is no same-edge ALE-to-read path.
- Write commit: at the first edge that samples `nWE`=0. Read-after-write to the same address returns the new data in the next access.
- Load visibility: a back-door load is visible to a bus read whose `nOE` is sampled on any later edge.
- Throughput: back-to-back accesses are allowed. An ALE on the edge after strobe release is accepted.

## Structure

- Shared package `memif_pkg` holds:
  - `memif_state_t`, the enum for the four states;
  - `BUS_W`=16.
- Sub-module `mem_array`:
  - parameters `AW`/`DW`;
  - two synchronous write ports with port A (bus) priority over port B (load);
  - one synchronous read port.
- `mem_responder` contains the FSM, the address latch and the error logic, and instantiates `mem_array`.
- The top level resolves the tri-state bus from `DataOut`/`DataOe`.

## Test plan

- Preload and read: load 0x0005 <= 0xBEEF, then run ALE with `BusIn`=0x0005 followed by `nOE` low with `nME` low → `DataOe`=1 and `DataOut`=0xBEEF one cycle after `nOE` is sampled, held until `nOE` rises, then `DataOe`=0.
- Write then read: bus write of 0x1234 to address 0x0A with `nWE` held low for 3 cycles → a later read of 0x0A returns 0x1234, and an internal write counter shows exactly 1 write.
- Chip select inactive: same write with `nME`=1 → address 0x0A unchanged, `DataOe` never asserted.
- Wrap: ALE with `BusIn`=0x0105 (`AW`=8) → a read returns the contents of 0x05.
- Conflict: `nOE`=`nWE`=0 together after ALE → `ProtErr`=1 and stays high, no write, `DataOe`=0. Asserting `nReset`=0 clears it.
- Abort and collision:
  - ALE during `READ` → `DataOe` drops at that edge.
  - Same-edge bus write of 0x1111 and load of 0x2222 to the same address → 0x1111 stored.
  - `nReset` pulsed mid-read → `DataOe` goes to 0 asynchronously.

Source files
------------

// File: rtl/memif_pkg.sv
// memif_pkg
// Shared definitions for the memory-side bus responder.
//   memif_state_t : responder FSM states (idle, address latched, read, write)
//   BUS_W         : width of the multiplexed address/data bus
package memif_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } memif_state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Word-addressed RAM with two synchronous write ports and one synchronous
// registered read port.
//   i_clk, i_rst_n       : clock, async active-low reset (read register only)
//   i_aWe/i_aAddr/i_aData : write port A (bus side), wins address collisions
//   i_bWe/i_bAddr/i_bData : write port B (back-door load side)
//   i_rdEn/i_rdAddr       : read request; data appears on o_rdData next edge
//   o_rdData              : registered read data, holds when no read requested
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_aWe,
  input  logic [AW-1:0] i_aAddr,
  input  logic [DW-1:0] i_aData,
  input  logic          i_bWe,
  input  logic [AW-1:0] i_bAddr,
  input  logic [DW-1:0] i_bData,
  input  logic          i_rdEn,
  input  logic [AW-1:0] i_rdAddr,
  output logic [DW-1:0] o_rdData
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdData;
  logic          w_bBlocked;

  // Port B is suppressed only when port A writes the very same word
  assign w_bBlocked = i_aWe && (i_aAddr == i_bAddr);

  // Storage is deliberately not reset so it maps onto plain RAM
  always_ff @(posedge i_clk) begin
    if (i_aWe) begin
      r_mem[i_aAddr] <= i_aData;
    end
    if (i_bWe && !w_bBlocked) begin
      r_mem[i_bAddr] <= i_bData;
    end
  end

  // Read register keeps its last value between reads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the multiplexed address/data bus. Latches the
// word address on ALE, then serves one read (nOE) or one write (nWE) while
// nME is low. DataOe is the enable for the board-level tri-state driver of
// DataOut onto the shared bus.
//   Clock, nReset              : clock, async active-low reset
//   BusIn                      : address during ALE, write data during nWE
//   ALE, nME, nOE, nWE         : bus control strobes
//   DataOut, DataOe            : registered read data and its drive enable
//   ProtErr                    : sticky error on simultaneous nOE/nWE
//   LoadWe, LoadAddr, LoadData : back-door preload port
module mem_responder
  import memif_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = BUS_W
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [DW-1:0] BusIn,
  input  logic          ALE,
  input  logic          nME,
  input  logic          nOE,
  input  logic          nWE,
  output logic [DW-1:0] DataOut,
  output logic          DataOe,
  output logic          ProtErr,
  input  logic          LoadWe,
  input  logic [AW-1:0] LoadAddr,
  input  logic [DW-1:0] LoadData
);

  memif_state_t  r_state;
  logic [AW-1:0] r_addr;
  logic          r_dataOe;
  logic          r_protErr;

  logic          w_inAddr;
  logic          w_rdEn;
  logic          w_busWe;
  logic          w_conflict;

  // ALE takes priority over everything, so strobe actions only fire without it
  assign w_inAddr   = (r_state == ST_ADDR) && !ALE;
  assign w_rdEn     = w_inAddr && !nME && !nOE && nWE;
  assign w_busWe    = w_inAddr && !nME && !nWE && nOE;
  assign w_conflict = !ALE && (r_state != ST_IDLE) && !nME && !nOE && !nWE;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_dataOe  <= 1'b0;
      r_protErr <= 1'b0;
    end else if (ALE) begin
      // Upper bus bits are dropped, so addresses wrap modulo the depth
      r_addr   <= BusIn[AW-1:0];
      r_state  <= ST_ADDR;
      r_dataOe <= 1'b0;
    end else if (w_conflict) begin
      r_protErr <= 1'b1;
      r_dataOe  <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_rdEn) begin
            r_dataOe <= 1'b1;
            r_state  <= ST_READ;
          end else if (w_busWe) begin
            r_state <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (nOE || nME) begin
            r_dataOe <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          // The single write already happened on entry; wait for release
          if (nWE) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_memArray (
    .i_clk    (Clock),
    .i_rst_n  (nReset),
    .i_aWe    (w_busWe),
    .i_aAddr  (r_addr),
    .i_aData  (BusIn),
    .i_bWe    (LoadWe),
    .i_bAddr  (LoadAddr),
    .i_bData  (LoadData),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (r_addr),
    .o_rdData (DataOut)
  );

  assign DataOe  = r_dataOe;
  assign ProtErr = r_protErr;

endmodule
